// File: rtl/equiv_check_sequencer_if.sv
// Stimulus/compare bus between the equivalence sequencer and the harness around the two DUTs.
// master = sequencer side, slave = harness side.
interface equiv_check_sequencer_if #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 20,
  parameter int CNT_W = 20
);
  logic             start;
  logic [31:0]      seed;
  logic [CNT_W-1:0] num_vectors;
  logic [IN_W-1:0]  stim;
  logic [OUT_W-1:0] spec_out;
  logic [OUT_W-1:0] impl_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      fail_count;
  logic [CNT_W-1:0] vec_count;
  logic [IN_W-1:0]  first_fail_stim;
  logic [OUT_W-1:0] first_fail_mask;

  modport master (
    input  start, seed, num_vectors, spec_out, impl_out,
    output stim, busy, done, pass, fail_count, vec_count, first_fail_stim, first_fail_mask
  );

  modport slave (
    output start, seed, num_vectors, spec_out, impl_out,
    input  stim, busy, done, pass, fail_count, vec_count, first_fail_stim, first_fail_mask
  );
endinterface

// File: rtl/equiv_check_sequencer.sv
// LFSR stimulus / settle / compare sequencer for spec-vs-impl equivalence runs.
// Optional macro EQCHK_STOP_ON_FAIL_EN: end the run at the first mismatching vector.
module equiv_check_sequencer #(
  parameter int IN_W   = 12,
  parameter int OUT_W  = 20,
  parameter int CNT_W  = 20,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  equiv_check_sequencer_if.master bus
);
  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam int          SW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_FINISH} state_e;

  state_e           state_q, state_d;
  logic [31:0]      lfsr_q, lfsr_d, lfsr_adv;
  logic [IN_W-1:0]  stim_q, stim_d, ffs_q, ffs_d;
  logic [OUT_W-1:0] ffm_q, ffm_d, diff;
  logic [SW-1:0]    settle_q, settle_d;
  logic [CNT_W-1:0] num_q, num_d, vec_q, vec_d, vec_inc;
  logic [15:0]      fail_q, fail_d;
  logic             pass_q, pass_d, mismatch;

  assign lfsr_adv = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
  assign vec_inc  = vec_q + CNT_W'(1);
  assign diff     = bus.spec_out ^ bus.impl_out;

  // case matching is exact in simulation, so any X/Z bit in diff lands in default
  always_comb begin
    case (diff)
      {OUT_W{1'b0}}: mismatch = 1'b0;
      default:       mismatch = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    stim_d   = stim_q;
    settle_d = settle_q;
    num_d    = num_q;
    vec_d    = vec_q;
    fail_d   = fail_q;
    ffs_d    = ffs_q;
    ffm_d    = ffm_q;
    pass_d   = pass_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          lfsr_d  = (bus.seed == 32'h0) ? 32'h1 : bus.seed;
          num_d   = bus.num_vectors;
          vec_d   = '0;
          fail_d  = '0;
          ffs_d   = '0;
          ffm_d   = '0;
          pass_d  = 1'b0;
          state_d = (bus.num_vectors == '0) ? S_FINISH : S_LOAD;
        end
      end
      S_LOAD: begin
        lfsr_d   = lfsr_adv;
        stim_d   = lfsr_adv[IN_W-1:0];
        settle_d = SW'(SETTLE - 1);
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == '0) state_d = S_CHECK;
        else                settle_d = settle_q - SW'(1);
      end
      S_CHECK: begin
        vec_d = vec_inc;
        if (mismatch) begin
          if (fail_q != 16'hFFFF) fail_d = fail_q + 16'd1;
          if (fail_q == 16'h0) begin
            ffs_d = stim_q;
            ffm_d = diff;
          end
        end
        state_d = (vec_inc == num_q) ? S_FINISH : S_LOAD;
`ifdef EQCHK_STOP_ON_FAIL_EN
        if (mismatch) state_d = S_FINISH;
`else
`endif
      end
      S_FINISH: begin
        pass_d  = (fail_q == 16'h0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= 32'h1;
      stim_q   <= '0;
      settle_q <= '0;
      num_q    <= '0;
      vec_q    <= '0;
      fail_q   <= '0;
      ffs_q    <= '0;
      ffm_q    <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      stim_q   <= stim_d;
      settle_q <= settle_d;
      num_q    <= num_d;
      vec_q    <= vec_d;
      fail_q   <= fail_d;
      ffs_q    <= ffs_d;
      ffm_q    <= ffm_d;
      pass_q   <= pass_d;
    end
  end

  assign bus.stim            = stim_q;
  assign bus.busy            = (state_q == S_LOAD) || (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign bus.done            = (state_q == S_FINISH);
  assign bus.pass            = pass_q;
  assign bus.fail_count      = fail_q;
  assign bus.vec_count       = vec_q;
  assign bus.first_fail_stim = ffs_q;
  assign bus.first_fail_mask = ffm_q;
endmodule
